// File: rtl/breadboard_pkg.sv
// Shared definitions for the truth-table breadboard stimulus path:
// sequencer state encoding, code/input widths and the Gray mapping helper.
package breadboard_pkg;

    localparam int unsigned NUM_INPUTS = 4;
    localparam int unsigned NUM_CODES  = 16;

    // Binary sweep index and the breadboard input vector {w,x,y,z}
    typedef logic [$clog2(NUM_CODES)-1:0] code_t;
    typedef logic [NUM_INPUTS-1:0]        inputs_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        STEP_WAIT
    } seq_state_t;

    // Reflected binary Gray code: adjacent indices differ in exactly one bit
    function automatic inputs_t bin2gray(input code_t b);
        return inputs_t'(b ^ (b >> 1));
    endfunction

endpackage

// File: rtl/input_sequencer_if.sv
// Control and stimulus bundle between a test controller and the
// input_sequencer. The controller (master) drives the sweep controls and
// observes the breadboard drive and status; the sequencer is the slave.
interface input_sequencer_if;
    import breadboard_pkg::*;

    // Sweep controls
    logic  start;
    logic  step_mode;
    logic  step;
    logic  pause;
    logic  abort;

    // Breadboard inputs, MSB first
    logic  w;
    logic  x;
    logic  y;
    logic  z;

    // Sweep status
    code_t code;
    logic  sample_valid;
    logic  busy;
    logic  done;

    modport master (
        output start, step_mode, step, pause, abort,
        input  w, x, y, z, code, sample_valid, busy, done
    );

    modport slave (
        input  start, step_mode, step, pause, abort,
        output w, x, y, z, code, sample_valid, busy, done
    );

endinterface

// File: rtl/dwell_counter.sv
// Settle-time counter for one breadboard code. Counts enabled cycles from
// zero and flags the terminal count DWELL-1. DWELL must be within 1..255.
module dwell_counter #(
    parameter int unsigned DWELL = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TERMINAL = 8'(DWELL - 1);

    logic [7:0] cnt;

    // Clear has priority so every new code starts its dwell from zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = (cnt == TERMINAL);

endmodule

// File: rtl/input_sequencer.sv
// Stimulus sequencer for the 4-input / 10-output truth-table breadboard.
// Sweeps {w,x,y,z} from START_CODE to END_CODE (modulo 16), holds each code
// for DWELL settle cycles and then raises sample_valid for one cycle.
// Supports free run, single-step, pause and abort.
//
// Build option INPUT_SEQ_GRAY_ORDER_EN: when defined, {w,x,y,z} carries the
// Gray code of the binary index so only one breadboard input toggles per
// advance; code itself always stays the binary index.
module input_sequencer
    import breadboard_pkg::*;
#(
    parameter int unsigned DWELL      = 10,
    parameter code_t       START_CODE = 4'h0,
    parameter code_t       END_CODE   = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input_sequencer_if.slave   bus
);

    seq_state_t state;
    seq_state_t state_nxt;

    code_t      code_r;
    code_t      code_nxt;
    inputs_t    drive_r;
    logic       done_r;

    logic       code_load;
    logic       code_inc;
    logic       done_set;
    logic       done_clr;
    logic       dwell_tc;

    // Breadboard input ordering for a given sweep index
    function automatic inputs_t code_to_inputs(input code_t c);
`ifdef INPUT_SEQ_GRAY_ORDER_EN
        return bin2gray(c);
`else
        return inputs_t'(c);
`endif
    endfunction

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != SETTLE),
        .enable ((state == SETTLE) && !bus.pause),
        .tc     (dwell_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and code/done update requests; abort overrides
    // every state, pause only matters in SETTLE and STEP_WAIT
    always_comb begin
        state_nxt = state;
        code_load = 1'b0;
        code_inc  = 1'b0;
        done_set  = 1'b0;
        done_clr  = 1'b0;
        if (bus.abort) begin
            state_nxt = IDLE;
            done_clr  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        code_load = 1'b1;
                        done_clr  = 1'b1;
                        state_nxt = SETTLE;
                    end
                end
                SETTLE: begin
                    if (!bus.pause && dwell_tc) begin
                        state_nxt = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (code_r == END_CODE) begin
                        done_set  = 1'b1;
                        state_nxt = IDLE;
                    end else if (bus.step_mode) begin
                        state_nxt = STEP_WAIT;
                    end else begin
                        code_inc  = 1'b1;
                        state_nxt = SETTLE;
                    end
                end
                STEP_WAIT: begin
                    if (bus.step && !bus.pause) begin
                        code_inc  = 1'b1;
                        state_nxt = SETTLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign code_nxt = code_load ? START_CODE : code_r + code_t'(1);

    // Index and breadboard drive move together, so w..z only change on a
    // code update and are stable for the whole dwell and sample cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r  <= '0;
            drive_r <= '0;
        end else if (code_load || code_inc) begin
            code_r  <= code_nxt;
            drive_r <= code_to_inputs(code_nxt);
        end
    end

    // Sticky completion flag
    always_ff @(posedge clk) begin
        if (rst || done_clr) begin
            done_r <= 1'b0;
        end else if (done_set) begin
            done_r <= 1'b1;
        end
    end

    assign bus.w            = drive_r[3];
    assign bus.x            = drive_r[2];
    assign bus.y            = drive_r[1];
    assign bus.z            = drive_r[0];
    assign bus.code         = code_r;
    assign bus.sample_valid = (state == SAMPLE);
    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_r;

endmodule

// File: doc/input_sequencer.md
Name: input_sequencer

Overview:
- Stimulus stage that sits directly upstream of the 4-input/10-output combinational truth-table breadboard.
- Drives the breadboard inputs w,x,y,z through a programmable range of 4-bit codes and holds each code for a fixed dwell.
- Issues a one-cycle sample_valid strobe once inputs have settled, so a downstream capture stage can latch f0..f9.
- Supports free-run sweep, single-step mode, pause and abort.

Parameters:
- DWELL, 10, settle cycles per code before the sample strobe; legal range 1..255.
- START_CODE, 4'h0, first code of the sweep.
- END_CODE, 4'hF, last code of the sweep (inclusive).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a sweep; sampled in IDLE only.
- step_mode  input  1  when 1, the sweep waits for step after each sample; sampled at each SAMPLE cycle.
- step  input  1  advance pulse used in STEP_WAIT.
- pause  input  1  level; freezes the dwell counter and blocks step.
- abort  input  1  returns to IDLE from any state.
- w  output  1  code bit 3 (MSB).
- x  output  1  code bit 2.
- y  output  1  code bit 1.
- z  output  1  code bit 0 (LSB).
- code  output  4  current binary sweep index.
- sample_valid  output  1  high for exactly one cycle per code; w..z are stable throughout that cycle.
- busy  output  1  high in SETTLE, SAMPLE and STEP_WAIT.
- done  output  1  sticky completion flag; cleared by start or abort.

Behaviour:
- Reset values: state=IDLE, code=0, w=x=y=z=0, sample_valid=0, busy=0, done=0.
- Priority: rst > abort > pause > start/step.
- IDLE:
  - start=1 -> code<=START_CODE, dwell_cnt<=0, done<=0, next state SETTLE.
- SETTLE:
  - If pause=0, dwell_cnt increments.
  - When dwell_cnt==DWELL-1 and pause=0 -> SAMPLE.
  - If pause=1, dwell_cnt holds and the state holds.
- SAMPLE:
  - Lasts exactly one cycle; sample_valid=1; pause is ignored.
  - If code==END_CODE -> IDLE with done<=1.
  - Else if step_mode=1 -> STEP_WAIT.
  - Else code<=code+1 (mod 16), dwell_cnt<=0 -> SETTLE.
- STEP_WAIT:
  - step=1 and pause=0 -> code<=code+1 (mod 16), dwell_cnt<=0 -> SETTLE.
  - step is ignored while pause=1.
- Outputs: w,x,y,z are registered alongside code and change only on code updates. sample_valid and busy are decoded from the state register.
- Latency:
  - start sampled in cycle N -> new code on w..z in cycle N+1.
  - First sample_valid in cycle N+1+DWELL.
  - Each code occupies DWELL+1 cycles in free run.
- Wrap-around: END_CODE < START_CODE sweeps through 4'hF -> 4'h0 (modulo 16). START_CODE==END_CODE gives a single sample.
- start while busy: ignored. start in the same cycle as abort: abort wins, and start is not honoured that cycle.
- abort: from any state -> IDLE next cycle. sample_valid=0, busy=0, done=0; code and w..z hold their last values.
- rst mid-sweep: all outputs go to their reset values on the next edge.
- step pulses in SETTLE or SAMPLE are ignored (not queued).

Optional Feature:
- Macro: INPUT_SEQ_GRAY_ORDER_EN.
- Defined: {w,x,y,z} = code ^ (code>>1), i.e. Gray-coded so exactly one breadboard input toggles per advance. code stays the binary index, and range and latency are unchanged.
- Undefined: {w,x,y,z} = code.

Decomposition:
- Shared package breadboard_pkg:
  - state encoding (IDLE, SETTLE, SAMPLE, STEP_WAIT);
  - NUM_INPUTS=4 and NUM_CODES=16;
  - a bin2gray function.
- One sub-module, dwell_counter:
  - clear and enable inputs;
  - terminal-count output at DWELL-1;
  - 8-bit counter.

Test Plan:
- Free run, DWELL=10, range 0..F: start pulse at cycle 5.
  - Expect w..z=0000 at cycle 6 and the first sample_valid at cycle 16.
  - Expect 16 strobes spaced 11 cycles apart, codes 0..15 in order.
  - Expect done=1 and busy=0 from cycle 182.
- Step mode, DWELL=2, range 3..5.
  - After the strobe for code 3, the FSM holds in STEP_WAIT for 20 cycles.
  - A step pulse gives code=4 on the next cycle and a strobe 3 cycles after the step.
- Pause, DWELL=4: assert pause for 6 cycles mid-SETTLE on code 7.
  - The strobe for code 7 is delayed by exactly 6 cycles.
  - No strobe while paused; a step pressed while paused is ignored.
- Wrap, range E..1: expect the code sequence E, F, 0, 1 with 4 strobes, then done=1.
- Abort during SETTLE of code 9.
  - Next cycle: busy=0, done=0, code=9, no strobe.
  - A subsequent start restarts at START_CODE.
- rst asserted mid-sweep: next cycle all outputs are 0. With INPUT_SEQ_GRAY_ORDER_EN defined, code=2 drives w..z=0011 and code=3 drives 0010.
